// File: rtl/surfboard_tile_seq.sv
// ============================================================================
// Module   : surfboard_tile_seq (with its 2x2 surfboard multiply core)
// Brief    : 4x4 x 4x4 matrix product by time-sharing a 2x2 core over tiles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module surfboard #(
    parameter int W      = 2,
    parameter int SIGNED = 1
) (
    input  logic [0:3][W-1:0] a,
    input  logic [0:3][W-1:0] b,
    output logic [0:3][W-1:0] p
);
    generate
        for (genvar i = 0; i < 4; i++) begin : g_elem
            localparam int R  = i / 2;
            localparam int CC = i % 2;
            logic          w_sa0, w_sa1, w_sb0, w_sb1;
            logic [2*W-1:0] w_a0, w_a1, w_b0, w_b1, w_f0, w_f1;

            // Operands are extended to 2W so the low W bits of the product
            // follow the chosen interpretation.
            assign w_sa0 = (SIGNED != 0) & a[2*R][W-1];
            assign w_sa1 = (SIGNED != 0) & a[2*R+1][W-1];
            assign w_sb0 = (SIGNED != 0) & b[CC][W-1];
            assign w_sb1 = (SIGNED != 0) & b[2+CC][W-1];
            assign w_a0  = {{W{w_sa0}}, a[2*R]};
            assign w_a1  = {{W{w_sa1}}, a[2*R+1]};
            assign w_b0  = {{W{w_sb0}}, b[CC]};
            assign w_b1  = {{W{w_sb1}}, b[2+CC]};
            assign w_f0  = w_a0 * w_b0;
            assign w_f1  = w_a1 * w_b1;
            assign p[i]  = w_f0[W-1:0] + w_f1[W-1:0];
        end
    endgenerate
endmodule

module surfboard_tile_seq #(
    parameter int W      = 2,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:15][W-1:0] A,
    input  logic [0:15][W-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:15][W-1:0] C,
    output logic               busy
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state, w_next;
    logic [2:0]          r_step;
    logic [0:15][W-1:0]  r_a, r_b, r_c;
    logic [0:3][W-1:0]   w_core_a, w_core_b, w_core_p;
    logic [0:3][3:0]     w_cidx;
    logic                w_tr, w_tc, w_k;

    assign w_tr = r_step[2];
    assign w_tc = r_step[1];
    assign w_k  = r_step[0];

    // Flat index {row[1:0], col[1:0]}: tile row/col supply the high bit of each.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_tile
            localparam logic I1 = 1'(i / 2);
            localparam logic I0 = 1'(i % 2);
            assign w_core_a[i] = r_a[{w_tr, I1, w_k, I0}];
            assign w_core_b[i] = r_b[{w_k, I1, w_tc, I0}];
            assign w_cidx[i]   = {w_tr, I1, w_tc, I0};
        end
    endgenerate

    surfboard #(.W(W), .SIGNED(SIGNED)) u_core (
        .a (w_core_a),
        .b (w_core_b),
        .p (w_core_p)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)      w_next = c_RUN;
            c_RUN:   if (r_step == 3'd7) w_next = c_DONE;
            c_DONE:  if (out_ready)     w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        busy      = (r_state == c_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_step <= 3'd0;
        end else if (r_state == c_IDLE && in_valid) begin
            r_a    <= A;
            r_b    <= B;
            r_c    <= '0;
            r_step <= 3'd0;
        end else if (r_state == c_RUN) begin
            for (int i = 0; i < 4; i++) begin
                r_c[w_cidx[i]] <= r_c[w_cidx[i]] + w_core_p[i];
            end
            r_step <= r_step + 3'd1;
        end
    end

    assign C = r_c;
endmodule

`default_nettype wire

// File: tb/tb_surfboard_tile_seq.sv
// ============================================================================
// Module   : tb_surfboard_tile_seq
// Brief    : Scoreboard bench for surfboard_tile_seq at W=2 signed and W=4 unsigned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_surfboard_tile_seq;
    typedef logic [0:15][1:0] m2_t;
    typedef logic [0:15][3:0] m4_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic in_valid2 = 1'b0, out_ready2 = 1'b1, in_ready2, out_valid2, busy2;
    logic in_valid4 = 1'b0, out_ready4 = 1'b1, in_ready4, out_valid4, busy4;
    m2_t  A2 = '0, B2 = '0, C2;
    m4_t  A4 = '0, B4 = '0, C4;

    int n_chk  = 0;
    int n_fail = 0;
    m2_t q2[$];
    m4_t q4[$];

    surfboard_tile_seq #(.W(2), .SIGNED(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A2), .B(B2), .out_valid(out_valid2), .out_ready(out_ready2),
        .C(C2), .busy(busy2)
    );

    surfboard_tile_seq #(.W(4), .SIGNED(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A4), .B(B4), .out_valid(out_valid4), .out_ready(out_ready4),
        .C(C4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic m2_t mm2(input m2_t a, input m2_t b);
        m2_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[4*i+k]) * int'(b[4*k+j]);
                r[4*i+j] = 2'(s);
            end
        return r;
    endfunction

    function automatic m4_t mm4(input m4_t a, input m4_t b);
        m4_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[4*i+k]) * int'(b[4*k+j]);
                r[4*i+j] = 4'(s);
            end
        return r;
    endfunction

    // Acceptances push the expected product; result handshakes pop and compare.
    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
            q4.delete();
        end else begin
            if (in_valid2 && in_ready2) q2.push_back(mm2(A2, B2));
            if (in_valid4 && in_ready4) q4.push_back(mm4(A4, B4));
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL c2_unexpected: got result %h, expected none", C2);
                end else chk("c2_scoreboard", 64'(C2), 64'(q2.pop_front()));
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL c4_unexpected: got result %h, expected none", C4);
                end else chk("c4_scoreboard", 64'(C4), 64'(q4.pop_front()));
            end
        end
    end

    task automatic send2(input m2_t a, input m2_t b);
        int n = 0;
        A2 = a; B2 = b; in_valid2 = 1'b1;
        while (!in_ready2 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("send2_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    task automatic wait_valid2(output int n);
        n = 0;
        while (!out_valid2 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("wait2_timeout", 64'(n), 64'(0));
    endtask

    m2_t ident2, bmod2, all3_2, all1_2;
    m4_t r_a, r_b;
    int  n, bc;
    logic seen;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ident2[i] = (i % 5 == 0) ? 2'd1 : 2'd0;
            bmod2[i]  = 2'(i % 4);
        end
        all3_2 = 32'hFFFF_FFFF;
        all1_2 = 32'h5555_5555;

        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready2), 64'(1));
        chk("rst_out_valid", 64'(out_valid2), 64'(0));
        chk("rst_busy", 64'(busy2), 64'(0));
        chk("rst_c2", 64'(C2), 64'(0));
        chk("rst_c4", 64'(C4), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity times B: latency and busy window.
        send2(ident2, bmod2);
        bc = busy2 ? 1 : 0;
        chk("e0_out_valid", 64'(out_valid2), 64'(0));
        n = 0;
        while (!out_valid2 && n < 50) begin
            @(posedge clk); #1; n++;
            if (busy2) bc++;
        end
        chk("latency", 64'(n), 64'(8));
        chk("busy_cycles", 64'(bc), 64'(8));
        chk("c_identity", 64'(C2), 64'(bmod2));
        @(posedge clk); #1;
        chk("e9_in_ready", 64'(in_ready2), 64'(1));
        chk("e9_out_valid", 64'(out_valid2), 64'(0));

        send2(all3_2, ident2);
        wait_valid2(n);
        chk("c_neg1", 64'(C2), 64'(32'hFFFF_FFFF));
        @(posedge clk); #1;
        send2(all1_2, all1_2);
        wait_valid2(n);
        chk("c_wrap0", 64'(C2), 64'(0));
        @(posedge clk); #1;

        // Backpressure: result held, new beat ignored.
        out_ready2 = 1'b0;
        send2(ident2, bmod2);
        wait_valid2(n);
        A2 = all1_2; B2 = all1_2; in_valid2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_c_stable", 64'(C2), 64'(bmod2));
            chk("bp_in_ready", 64'(in_ready2), 64'(0));
            chk("bp_out_valid", 64'(out_valid2), 64'(1));
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'(in_ready2), 64'(1));
        send2(all3_2, ident2);
        wait_valid2(n);
        chk("bp_next", 64'(C2), 64'(32'hFFFF_FFFF));
        @(posedge clk); #1;

        // Reset during step 4 aborts the beat.
        send2(ident2, bmod2);
        repeat (4) begin @(posedge clk); #1; end
        chk("pre_rst_busy", 64'(busy2), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready2), 64'(1));
        chk("abort_busy", 64'(busy2), 64'(0));
        chk("abort_c", 64'(C2), 64'(0));
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (out_valid2) seen = 1'b1; end
        chk("abort_no_valid", 64'(seen), 64'(0));
        send2(ident2, all3_2);
        wait_valid2(n);
        chk("after_abort", 64'(C2), 64'(32'hFFFF_FFFF));
        @(posedge clk); #1;

        // Back-to-back with in_valid and out_ready held high.
        A2 = ident2; B2 = bmod2; in_valid2 = 1'b1;
        @(posedge clk); #1;
        A2 = all3_2; B2 = ident2;
        n = 0;
        while (!in_ready2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("b2b_spacing", 64'(n + 1), 64'(10));
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        wait_valid2(n);
        chk("b2b_second", 64'(C2), 64'(32'hFFFF_FFFF));
        @(posedge clk); #1;

        // W=4 unsigned: directed then random stream.
        A4 = 64'h3333_3333_3333_3333; B4 = 64'h3333_3333_3333_3333; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 50) begin @(posedge clk); #1; n++; end
        chk("c4_all4", 64'(C4), 64'h4444_4444_4444_4444);
        @(posedge clk); #1;
        for (int t = 0; t < 1000; t++) begin
            r_a = {$urandom, $urandom};
            r_b = {$urandom, $urandom};
            A4 = r_a; B4 = r_b; in_valid4 = 1'b1;
            n = 0;
            while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) chk("send4_timeout", 64'(n), 64'(0));
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("q2_drained", 64'(q2.size()), 64'(0));
        chk("q4_drained", 64'(q4.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
